// File: rtl/tex_spi_reader.sv
// tex_spi_reader: single-I/O SPI flash read initiator (mode 0, MSB first).
// Sends a command byte, then ADDR_W address bits, then clocks in DATA_W bits
// on i_tex_in1. SCLK runs at i_clk/2. Every pin output comes from a flop.
// Optional build macro TEX_SPI_FASTREAD_EN: the command becomes 0x0B (FAST
// READ) and 8 dummy SCLK cycles are inserted between address and data.
module tex_spi_reader #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 24
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_data,
  output logic              o_tex_csb,
  output logic              o_tex_sclk,
  output logic              o_tex_out0,
  output logic              o_tex_oeb0,
  input  logic              i_tex_in1
);

  localparam int TX_W    = 8 + ADDR_W;
  localparam int MAX_LEN = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W   = $clog2(MAX_LEN);

`ifdef TEX_SPI_FASTREAD_EN
  localparam logic [7:0] CMD_BYTE = 8'h0B;
`else
  localparam logic [7:0] CMD_BYTE = 8'h03;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
`ifdef TEX_SPI_FASTREAD_EN
    ST_DUMMY = 3'd3,
`endif
    ST_DATA  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              phase_q, phase_d;   // 0: SCLK low half, 1: SCLK high half
  logic [CNT_W-1:0]  cnt_q, cnt_d;       // bits left in the current phase, minus one
  logic [TX_W-1:0]   tx_q, tx_d;         // command + address, shifted out MSB first
  logic [DATA_W-1:0] rx_q, rx_d;         // incoming data shift register
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              csb_q, csb_d;
  logic              sclk_q, sclk_d;
  logic              out0_q, out0_d;
  logic              oeb0_q, oeb0_d;
  logic              drive_s;            // next state drives io0

  // Next-state, bit sequencing and pin values derived from the next state
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    data_d  = data_q;
    done_d  = 1'b0;
    sclk_d  = sclk_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_CMD;
          tx_d    = {CMD_BYTE, i_addr};
          cnt_d   = CNT_W'(7);
          phase_d = 1'b0;
          sclk_d  = 1'b0;
        end else begin
          sclk_d  = 1'b0;
        end
      end
      ST_CMD,
`ifdef TEX_SPI_FASTREAD_EN
      ST_DUMMY,
`endif
      ST_ADDR,
      ST_DATA: begin
        if (!phase_q) begin
          phase_d = 1'b1;
          sclk_d  = 1'b1;
        end else begin
          // Falling edge: close the current bit and move to the next one
          phase_d = 1'b0;
          sclk_d  = 1'b0;
          tx_d    = tx_q << 1;
          if (state_q == ST_DATA) begin
            rx_d = {rx_q[DATA_W-2:0], i_tex_in1};
          end else begin
            rx_d = rx_q;
          end
          if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            case (state_q)
              ST_CMD: begin
                state_d = ST_ADDR;
                cnt_d   = CNT_W'(ADDR_W - 1);
              end
              ST_ADDR: begin
`ifdef TEX_SPI_FASTREAD_EN
                state_d = ST_DUMMY;
                cnt_d   = CNT_W'(7);
`else
                state_d = ST_DATA;
                cnt_d   = CNT_W'(DATA_W - 1);
`endif
              end
`ifdef TEX_SPI_FASTREAD_EN
              ST_DUMMY: begin
                state_d = ST_DATA;
                cnt_d   = CNT_W'(DATA_W - 1);
              end
`endif
              ST_DATA: begin
                state_d = ST_DONE;
                cnt_d   = {CNT_W{1'b0}};
                data_d  = rx_d;
                done_d  = 1'b1;
              end
              default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
              end
            endcase
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        sclk_d  = 1'b0;
      end
    endcase

    // Chip select and busy follow the next state
    if (state_d == ST_IDLE || state_d == ST_DONE) begin
      csb_d = 1'b1;
    end else begin
      csb_d = 1'b0;
    end
    if (state_d == ST_IDLE) begin
      busy_d = 1'b0;
    end else begin
      busy_d = 1'b1;
    end

    // io0 is driven only while command and address bits are going out
    drive_s = (state_d == ST_CMD) || (state_d == ST_ADDR);
    if (drive_s) begin
      oeb0_d = 1'b0;
      out0_d = tx_d[TX_W-1];
    end else begin
      oeb0_d = 1'b1;
      out0_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      phase_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      tx_q    <= {TX_W{1'b0}};
      rx_q    <= {DATA_W{1'b0}};
      data_q  <= {DATA_W{1'b0}};
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      csb_q   <= 1'b1;
      sclk_q  <= 1'b0;
      out0_q  <= 1'b0;
      oeb0_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      csb_q   <= csb_d;
      sclk_q  <= sclk_d;
      out0_q  <= out0_d;
      oeb0_q  <= oeb0_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_data     = data_q;
  assign o_tex_csb  = csb_q;
  assign o_tex_sclk = sclk_q;
  assign o_tex_out0 = out0_q;
  assign o_tex_oeb0 = oeb0_q;

endmodule

// File: tb/tb_tex_spi_reader.sv
// Bench for tex_spi_reader: behavioural SPI flash responder plus a scoreboard
// of expected read results and headers, checked whenever o_done fires.
module tb_tex_spi_reader;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 24;
`ifdef TEX_SPI_FASTREAD_EN
  localparam logic [7:0] CMD = 8'h0B;
  localparam int DUMMY = 8;
`else
  localparam logic [7:0] CMD = 8'h03;
  localparam int DUMMY = 0;
`endif
  localparam int NBITS = 8 + ADDR_W + DUMMY + DATA_W;
  localparam int LAT   = 2 * NBITS;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic              tex_in1 = 1'b0;
  logic              o_busy, o_done, o_tex_csb, o_tex_sclk, o_tex_out0, o_tex_oeb0;
  logic [DATA_W-1:0] o_data;

  always #5 clk = ~clk;

  tex_spi_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_addr(addr),
    .o_busy(o_busy), .o_done(o_done), .o_data(o_data),
    .o_tex_csb(o_tex_csb), .o_tex_sclk(o_tex_sclk), .o_tex_out0(o_tex_out0),
    .o_tex_oeb0(o_tex_oeb0), .i_tex_in1(tex_in1)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Flash contents; unwritten bytes read as 0x00
  logic [7:0] mem [logic [23:0]];

  function automatic logic [7:0] rd(input logic [23:0] a);
    if (mem.exists(a)) return mem[a];
    else return 8'h00;
  endfunction

  function automatic logic [DATA_W-1:0] exp_data(input logic [23:0] a);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < DATA_W / 8; i++) d = (d << 8) | DATA_W'(rd(a + 24'(i)));
    return d;
  endfunction

  // Flash responder: header sampled on SCLK rise, data shifted out on SCLK fall
  int         f_bits = 0, f_edges = 0, f_dummy = 0, f_oeb_err = 0;
  logic [31:0] f_hdr = '0;

  function automatic int hdr_len(input logic [31:0] h);
    return (h[31:24] == 8'h0B) ? 40 : 32;
  endfunction

  always @(negedge o_tex_csb or posedge o_tex_sclk) begin
    if (!o_tex_sclk) begin
      f_bits = 0; f_edges = 0; f_dummy = 0; f_oeb_err = 0;
    end else if (!o_tex_csb) begin
      f_edges++;
      if (f_bits < 32) begin
        f_hdr = {f_hdr[30:0], o_tex_out0};
        if (o_tex_oeb0 !== 1'b0) f_oeb_err++;
      end else if (f_bits < hdr_len(f_hdr)) begin
        if (o_tex_oeb0 === 1'b1) f_dummy++;
        else f_oeb_err++;
      end else if (o_tex_oeb0 !== 1'b1) begin
        f_oeb_err++;
      end
      f_bits++;
    end
  end

  always @(negedge o_tex_sclk) begin
    if (!o_tex_csb && f_bits >= hdr_len(f_hdr)) begin
      int j;
      logic [7:0] b;
      j = f_bits - hdr_len(f_hdr);
      b = rd(f_hdr[23:0] + 24'(j / 8));
      tex_in1 = b[7 - (j % 8)];
    end
  end

  // Scoreboard and timing monitor
  logic [DATA_W-1:0] exp_q[$];
  logic [31:0]       hdr_q[$];
  int   cyc = 0, acc_cyc = 0, done_cnt = 0, hi_cnt = 0, last_hi = 0;
  logic busy_prev = 1'b0, csb_prev = 1'b1;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (o_busy && !busy_prev) acc_cyc = cyc;
    if (o_tex_csb) hi_cnt++;
    else if (csb_prev) begin
      last_hi = hi_cnt;
      hi_cnt = 0;
    end
    if (o_done) begin
      done_cnt++;
      check_eq("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0 && hdr_q.size() > 0) begin
        check_eq("data", o_data, exp_q.pop_front());
        check_eq("header", f_hdr, hdr_q.pop_front());
        check_eq("latency", cyc - acc_cyc, LAT);
        check_eq("csb_at_done", o_tex_csb, 1'b1);
        check_eq("sclk_edges", f_edges, NBITS);
        check_eq("dummy_edges", f_dummy, DUMMY);
        check_eq("oeb_errors", f_oeb_err, 0);
      end
    end
    busy_prev = o_busy;
    csb_prev  = o_tex_csb;
  end

  task automatic wait_done(input int budget);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_seen", done_cnt != d0, 1);
  endtask

  task automatic launch(input logic [23:0] a);
    @(negedge clk);
    start = 1'b1;
    addr  = a;
    exp_q.push_back(exp_data(a));
    hdr_q.push_back({CMD, a});
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int d0;
    mem[24'h000100] = 8'hAB; mem[24'h000101] = 8'hCD; mem[24'h000102] = 8'hEF;
    mem[24'h000103] = 8'h12; mem[24'h000104] = 8'h34; mem[24'h000105] = 8'h56;
    mem[24'hFFFFFD] = 8'h11; mem[24'hFFFFFE] = 8'h22; mem[24'hFFFFFF] = 8'h33;
    mem[24'h000000] = 8'h77;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_csb", o_tex_csb, 1'b1);
    check_eq("rst_sclk", o_tex_sclk, 1'b0);
    check_eq("rst_out0", o_tex_out0, 1'b0);
    check_eq("rst_oeb0", o_tex_oeb0, 1'b1);
    check_eq("rst_busy", o_busy, 1'b0);
    check_eq("rst_done", o_done, 1'b0);
    check_eq("rst_data", o_data, 0);
    rst = 1'b0;

    // Basic read
    launch(24'h000100);
    wait_done(LAT + 10);

    // Start during an active read is ignored
    d0 = done_cnt;
    launch(24'h000100);
    repeat (38) @(negedge clk);
    start = 1'b1;
    addr  = 24'h000200;
    @(negedge clk);
    start = 1'b0;
    wait_done(LAT + 10);
    repeat (150) @(negedge clk);
    check_eq("one_done", done_cnt - d0, 1);

    // Reset during ADDR aborts the read
    launch(24'h000100);
    repeat (28) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    hdr_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    check_eq("abort_csb", o_tex_csb, 1'b1);
    check_eq("abort_sclk", o_tex_sclk, 1'b0);
    check_eq("abort_oeb0", o_tex_oeb0, 1'b1);
    check_eq("abort_busy", o_busy, 1'b0);
    check_eq("abort_data", o_data, 0);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    check_eq("abort_no_done", done_cnt - d0, 0);
    launch(24'h000100);
    wait_done(LAT + 10);

    // Back-to-back with start held through o_done
    @(negedge clk);
    start = 1'b1;
    addr  = 24'h000100;
    exp_q.push_back(exp_data(24'h000100));
    hdr_q.push_back({CMD, 24'h000100});
    for (int i = 0; i < LAT + 10; i++) begin
      @(negedge clk);
      if (o_done) break;
    end
    check_eq("b2b_first_done", o_done, 1'b1);
    addr = 24'h000103;
    exp_q.push_back(exp_data(24'h000103));
    hdr_q.push_back({CMD, 24'h000103});
    @(negedge clk);
    check_eq("b2b_gap_idle", o_busy, 1'b0);
    @(negedge clk);
    check_eq("b2b_reaccept", o_busy, 1'b1);
    start = 1'b0;
    @(negedge clk);
    check_eq("b2b_csb_high", last_hi, 2);
    wait_done(LAT + 10);

    // Address near the top of the map
    launch(24'hFFFFFD);
    wait_done(LAT + 10);

    repeat (5) @(negedge clk);
    check_eq("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
